param_regfile: RTL and testbench
================================

PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL expose parameter DATA_W, default 32, data width in bits.
REQ-002 SHALL expose parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL expose parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL expose parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 SHALL expose parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and is never written.
REQ-006 SHALL expose parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to matching reads.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, NUM_WR, per-port write enable.
REQ-010 SHALL have port w_addr, input, NUM_WR*ADDR_W, packed write addresses, port 0 in LSBs.
REQ-011 SHALL have port w_data, input, NUM_WR*DATA_W, packed write data, port 0 in LSBs.
REQ-012 SHALL have port r_addr, input, NUM_RD*ADDR_W, packed read addresses, port 0 in LSBs.
REQ-013 SHALL have port r_data, output, NUM_RD*DATA_W, packed combinational read data.
REQ-014 SHALL have port clr_req, input, 1, single-cycle request for a sequential clear sweep.
REQ-015 SHALL have port busy, output, 1, high while the clear sweep runs.
REQ-016 SHALL have port clr_done, output, 1, one-cycle pulse on the cycle the final entry is cleared.

Function
REQ-017 SHALL write w_data[k] to entry w_addr[k] at the rising edge when wr_en[k]=1 and busy=0.
REQ-018 SHALL, when both write ports target the same address in one cycle, store port 1 data (higher index wins).
REQ-019 SHALL ignore writes to address 0 when ZERO_REG=1; r_data for address 0 is then always 0.
REQ-020 SHALL drive each r_data port combinationally from r_addr with zero cycles of latency.
REQ-021 SHALL, when BYPASS=1 and busy=0, return the winning write port's w_data on any read port whose r_addr equals an enabled w_addr (address 0 excluded under ZERO_REG).
REQ-022 SHALL, when BYPASS=0, return the pre-edge stored value during a same-address write.
REQ-023 SHALL implement clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1 in IDLE.
REQ-024 SHALL, in CLEAR, zero entry cnt each cycle, with cnt counting 0..DEPTH-1 from 0, so a sweep lasts exactly DEPTH cycles.
REQ-025 SHALL assert busy for exactly the DEPTH cycles spent in CLEAR.
REQ-026 SHALL pulse clr_done in the cycle cnt=DEPTH-1, then return to IDLE with cnt=0 on the next edge.
REQ-027 SHALL ignore clr_req while busy=1; no restart and no queuing.
REQ-028 SHALL discard all writes while busy=1; there is no back-pressure, and the caller observes busy.
REQ-029 SHALL, during CLEAR, return stored contents on reads (entries already swept read 0), with bypass disabled.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously clear all entries to 0, FSM to IDLE, cnt to 0, busy=0, and clr_done=0.
REQ-031 SHALL abort a sweep in progress on rst_n=0; no clr_done is issued for the aborted sweep.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL place the default DATA_W/ADDR_W/NUM_RD/NUM_WR values and the FSM state encodings (IDLE=0, CLEAR=1) in shared package regfile_pkg.
REQ-034 SHALL implement the clear FSM and counter as sub-module regfile_clr_fsm (outputs: busy, clr_done, clr_addr, clr_we).
REQ-035 SHALL keep the storage array, write-port arbitration, and read/bypass muxes in param_regfile itself.

Verification
REQ-036 SHALL cover: write 32'h0000_0004 to addr 3 via port 0, then read addr 3 on ports 0/1 next cycle -> both return 32'h0000_0004.
REQ-037 SHALL cover: port 0 and port 1 both write addr 7, with 32'h1111_1111 and 32'h2222_2222 -> addr 7 reads 32'h2222_2222.
REQ-038 SHALL cover: write 32'hDEAD_BEEF to addr 0 with ZERO_REG=1 -> addr 0 reads 0, both in the same cycle and afterwards.
REQ-039 SHALL cover: BYPASS=1, write 32'hAAAA_AAAA to addr 30 while r_addr=30 in the same cycle -> r_data=32'hAAAA_AAAA before the edge; with BYPASS=0 the old value is returned instead.
REQ-040 SHALL cover: fill all 32 entries, pulse clr_req -> busy high 32 cycles, clr_done pulses once on cycle 32, all reads 0 afterwards; a write issued during the sweep is lost.
REQ-041 SHALL cover: drop rst_n at sweep cycle 10 -> busy falls immediately, no clr_done, all entries 0, and a fresh clr_req after reset yields a full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sweep state encoding for the parameterised register file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int NUM_WR_DEF = 2;

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_e;
endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep sequencer: walks every entry once, zeroing one per cycle.
//   state     | meaning
//   CLR_IDLE  | waiting for clr_req; busy low
//   CLR_CLEAR | zeroing entry cnt_q each cycle; busy high
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              clr_we
);
   localparam logic [ADDR_W-1:0] LAST   = '1;
   localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(2**ADDR_W - 2);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            CLR_IDLE: begin
               done_q <= 1'b0;
               if (clr_req) begin
                  state_q <= CLR_CLEAR;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            CLR_CLEAR: begin
               if (cnt_q == LAST) begin
                  state_q <= CLR_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + 1'b1;
                  // done is registered, so raise it one edge ahead of the final entry
                  done_q <= (cnt_q == PENULT);
               end
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign clr_done = done_q;
   assign clr_addr = cnt_q;
   assign clr_we   = busy_q;
endmodule

// File: rtl/param_regfile.sv
// Multi-port register file with optional hard-zero entry 0, write-to-read bypass
// and a sequential clear sweep.
module param_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = NUM_RD_DEF,
   parameter int NUM_WR   = NUM_WR_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] w_addr,
   input  logic [NUM_WR*DATA_W-1:0] w_data,
   input  logic [NUM_RD*ADDR_W-1:0] r_addr,
   output logic [NUM_RD*DATA_W-1:0] r_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_we;

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return !(ZERO_REG && (a == '0));
   endfunction

   regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   // Later ports overwrite earlier ones, so the highest enabled index wins a collision.
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && writable(w_addr[k*ADDR_W +: ADDR_W]))
               mem_d[w_addr[k*ADDR_W +: ADDR_W]] = w_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = r_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
         rd = mem_q[ra];
         if (!writable(ra)) begin
            rd = '0;
         end else if (BYPASS && !busy) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_en[k] && (w_addr[k*ADDR_W +: ADDR_W] == ra))
                  rd = w_data[k*DATA_W +: DATA_W];
            end
         end
      end

      assign r_data[i*DATA_W +: DATA_W] = rd;
   end
endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: directed scenarios plus randomized traffic against an array model.
module tb_param_regfile;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] w_addr;
   logic [NW*DW-1:0] w_data;
   logic [NR*AW-1:0] r_addr;
   logic [NR*DW-1:0] r_data;
   logic [NR*DW-1:0] r_data_nb;
   logic             clr_req;
   logic             busy, busy_nb;
   logic             clr_done, clr_done_nb;

   int vectors    = 0;
   int miscompares = 0;

   logic [DW-1:0] model [DEPTH];
   bit            m_busy;
   int            m_sweep;

   always #5 clk = ~clk;

   param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                   .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
      .r_addr(r_addr), .r_data(r_data), .clr_req(clr_req), .busy(busy), .clr_done(clr_done));

   param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                   .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
      .r_addr(r_addr), .r_data(r_data_nb), .clr_req(clr_req), .busy(busy_nb),
      .clr_done(clr_done_nb));

   function automatic logic [DW-1:0] exp_read(input int a, input bit byp);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = model[a];
      if (byp && !m_busy)
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && int'(w_addr[k*AW +: AW]) == a) v = w_data[k*DW +: DW];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      m_busy  = 1'b0;
      m_sweep = 0;
   endtask

   task automatic model_edge();
      if (m_busy) begin
         model[m_sweep] = '0;
         if (m_sweep == DEPTH-1) begin
            m_busy  = 1'b0;
            m_sweep = 0;
         end else m_sweep++;
      end else begin
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && w_addr[k*AW +: AW] != '0)
               model[int'(w_addr[k*AW +: AW])] = w_data[k*DW +: DW];
         if (clr_req) begin
            m_busy  = 1'b1;
            m_sweep = 0;
         end
      end
   endtask

   task automatic clk_edge();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = '0; w_addr = '0; w_data = '0; r_addr = '0; clr_req = 1'b0;
   endtask

   task automatic test_reset();
      for (int a = 0; a < DEPTH; a++) begin
         r_addr = {AW'(DEPTH-1-a), AW'(a)};
         #0.1;
         vectors++;
         if (r_data !== '0) begin
            miscompares++;
            $display("FAIL reset_rdata a=%0d got=%h exp=0", a, r_data);
         end
      end
      vectors++;
      if (busy !== 1'b0 || clr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status busy=%b done=%b exp=0/0", busy, clr_done);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      idle_inputs();
      wr_en = 2'b01; w_addr = {AW'(0), AW'(3)}; w_data = {32'h0, 32'h0000_0004};
      clk_edge();
      wr_en = '0;
      r_addr = {AW'(3), AW'(3)};
      #1;
      for (int p = 0; p < NR; p++) begin
         vectors++;
         if (r_data[p*DW +: DW] !== 32'h0000_0004 || r_data_nb[p*DW +: DW] !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL basic_read p=%0d got=%h/%h exp=00000004", p,
                     r_data[p*DW +: DW], r_data_nb[p*DW +: DW]);
         end
      end
   endtask

   task automatic test_same_addr();
      idle_inputs();
      wr_en = 2'b11; w_addr = {AW'(7), AW'(7)}; w_data = {32'h2222_2222, 32'h1111_1111};
      r_addr = {AW'(7), AW'(7)};
      #1;
      vectors++;
      if (r_data[DW-1:0] !== 32'h2222_2222) begin
         miscompares++;
         $display("FAIL collide_bypass got=%h exp=22222222", r_data[DW-1:0]);
      end
      clk_edge();
      wr_en = '0;
      #1;
      for (int p = 0; p < NR; p++) begin
         vectors++;
         if (r_data[p*DW +: DW] !== 32'h2222_2222 || r_data_nb[p*DW +: DW] !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL collide_store p=%0d got=%h/%h exp=22222222", p,
                     r_data[p*DW +: DW], r_data_nb[p*DW +: DW]);
         end
      end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      wr_en = 2'b01; w_addr = '0; w_data = {32'h0, 32'hDEAD_BEEF};
      r_addr = '0;
      #1;
      vectors++;
      if (r_data !== '0 || r_data_nb !== '0) begin
         miscompares++;
         $display("FAIL zero_same_cycle got=%h/%h exp=0", r_data, r_data_nb);
      end
      clk_edge();
      wr_en = '0;
      #1;
      vectors++;
      if (r_data !== '0 || r_data_nb !== '0) begin
         miscompares++;
         $display("FAIL zero_after got=%h/%h exp=0", r_data, r_data_nb);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      wr_en = 2'b10; w_addr = {AW'(30), AW'(0)}; w_data = {32'h5555_5555, 32'h0};
      clk_edge();
      wr_en = 2'b01; w_addr = {AW'(0), AW'(30)}; w_data = {32'h0, 32'hAAAA_AAAA};
      r_addr = {AW'(30), AW'(30)};
      #1;
      vectors++;
      if (r_data !== {32'hAAAA_AAAA, 32'hAAAA_AAAA}) begin
         miscompares++;
         $display("FAIL bypass_on got=%h exp=aaaaaaaaaaaaaaaa", r_data);
      end
      vectors++;
      if (r_data_nb !== {32'h5555_5555, 32'h5555_5555}) begin
         miscompares++;
         $display("FAIL bypass_off got=%h exp=5555555555555555", r_data_nb);
      end
      clk_edge();
      wr_en = '0;
      #1;
      vectors++;
      if (r_data[DW-1:0] !== 32'hAAAA_AAAA || r_data_nb[DW-1:0] !== 32'hAAAA_AAAA) begin
         miscompares++;
         $display("FAIL bypass_store got=%h/%h exp=aaaaaaaa", r_data[DW-1:0], r_data_nb[DW-1:0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         wr_en   = NW'($urandom_range(0, 3));
         w_addr  = NW*AW'($urandom);
         w_data  = {$urandom, $urandom};
         for (int p = 0; p < NR; p++)
            r_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ?
               w_addr[$urandom_range(0, NW-1)*AW +: AW] : AW'($urandom);
         clr_req = ($urandom_range(0, 49) == 0);
         #1;
         for (int p = 0; p < NR; p++) begin
            vectors++;
            if (r_data[p*DW +: DW] !== exp_read(int'(r_addr[p*AW +: AW]), 1'b1) ||
                r_data_nb[p*DW +: DW] !== exp_read(int'(r_addr[p*AW +: AW]), 1'b0)) begin
               miscompares++;
               $display("FAIL rand_read n=%0d p=%0d a=%0d got=%h/%h exp=%h/%h", n, p,
                        r_addr[p*AW +: AW], r_data[p*DW +: DW], r_data_nb[p*DW +: DW],
                        exp_read(int'(r_addr[p*AW +: AW]), 1'b1),
                        exp_read(int'(r_addr[p*AW +: AW]), 1'b0));
            end
         end
         vectors++;
         if (busy !== m_busy || busy_nb !== m_busy ||
             clr_done !== (m_busy && m_sweep == DEPTH-1) ||
             clr_done_nb !== (m_busy && m_sweep == DEPTH-1)) begin
            miscompares++;
            $display("FAIL rand_status n=%0d busy=%b/%b done=%b/%b exp busy=%b done=%b", n,
                     busy, busy_nb, clr_done, clr_done_nb, m_busy, m_busy && m_sweep == DEPTH-1);
         end
         clk_edge();
      end
      idle_inputs();
      for (int c = 0; c < 2*DEPTH && m_busy; c++) clk_edge();
   endtask

   task automatic sweep_count(input bit inject_write, output int bc, output int dc, output int dat);
      bc = 0; dc = 0; dat = -1;
      for (int c = 0; c < 2*DEPTH; c++) begin
         if (!busy) break;
         bc++;
         if (clr_done) begin
            dc++;
            dat = bc;
         end
         if (inject_write && bc == 4) begin
            wr_en = 2'b01; w_addr = {AW'(0), AW'(1)}; w_data = {32'h0, 32'h1234_5678};
         end else wr_en = '0;
         clk_edge();
      end
      wr_en = '0;
   endtask

   task automatic test_clear();
      int bc, dc, dat;
      idle_inputs();
      for (int i = 0; i < DEPTH/2; i++) begin
         wr_en  = 2'b11;
         w_addr = {AW'(2*i+1), AW'(2*i)};
         w_data = {$urandom | 32'h1, $urandom | 32'h1};
         clk_edge();
      end
      wr_en = '0;
      r_addr = {AW'(31), AW'(1)};
      #1;
      vectors++;
      if (r_data[DW-1:0] !== model[1] || r_data[2*DW-1:DW] !== model[31]) begin
         miscompares++;
         $display("FAIL fill_read got=%h exp=%h%h", r_data, model[31], model[1]);
      end
      clr_req = 1'b1;
      clk_edge();
      clr_req = 1'b0;
      sweep_count(1'b1, bc, dc, dat);
      vectors++;
      if (bc !== 32 || dc !== 1 || dat !== 32) begin
         miscompares++;
         $display("FAIL sweep_timing busy_cycles=%0d done_pulses=%0d done_at=%0d exp=32/1/32",
                  bc, dc, dat);
      end
      for (int a = 0; a < DEPTH; a++) begin
         r_addr = {AW'(DEPTH-1-a), AW'(a)};
         #1;
         vectors++;
         if (r_data !== '0 || r_data_nb !== '0) begin
            miscompares++;
            $display("FAIL after_sweep a=%0d got=%h/%h exp=0", a, r_data, r_data_nb);
         end
      end
   endtask

   task automatic test_reset_abort();
      int bc, dc, dat;
      idle_inputs();
      wr_en = 2'b11; w_addr = {AW'(20), AW'(9)}; w_data = {32'hCAFE_0020, 32'hCAFE_0009};
      clk_edge();
      wr_en = '0;
      clr_req = 1'b1;
      clk_edge();
      clr_req = 1'b0;
      for (int c = 0; c < 10; c++) clk_edge();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_pre busy=%b exp=1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (busy !== 1'b0 || busy_nb !== 1'b0 || clr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_status busy=%b/%b done=%b exp=0", busy, busy_nb, clr_done);
      end
      for (int a = 0; a < DEPTH; a++) begin
         r_addr = {AW'(DEPTH-1-a), AW'(a)};
         #0.1;
         vectors++;
         if (r_data !== '0) begin
            miscompares++;
            $display("FAIL abort_clear a=%0d got=%h exp=0", a, r_data);
         end
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (clr_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_hold done=%b busy=%b exp=0/0", clr_done, busy);
         end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr_req = 1'b1;
      clk_edge();
      clr_req = 1'b0;
      sweep_count(1'b0, bc, dc, dat);
      vectors++;
      if (bc !== 32 || dc !== 1 || dat !== 32) begin
         miscompares++;
         $display("FAIL resweep busy_cycles=%0d done_pulses=%0d done_at=%0d exp=32/1/32",
                  bc, dc, dat);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #2;
      test_reset();
      test_basic();
      test_same_addr();
      test_zero_reg();
      test_bypass();
      test_random();
      test_clear();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "bench time limit reached");
   end
endmodule
